// File: rtl/judgement_plotter_pkg.sv
// Shared judgement codes, colours, glyph geometry and plotter state encodings.
// Also used by the rhythm datapath and hex_accuracy.
package judgement_plotter_pkg;

    localparam logic [1:0] ACC_NONE    = 2'b00;
    localparam logic [1:0] ACC_PERFECT = 2'b01;
    localparam logic [1:0] ACC_GOOD    = 2'b10;
    localparam logic [1:0] ACC_MISS    = 2'b11;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_RED   = 3'b100;

    localparam int unsigned GLYPH_W = 8;
    localparam int unsigned GLYPH_H = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DRAW = 1'b1;

    function automatic logic [2:0] code_colour(input logic [1:0] code);
        case (code)
            ACC_PERFECT: code_colour = COL_GREEN;
            ACC_GOOD:    code_colour = COL_BLUE;
            ACC_MISS:    code_colour = COL_RED;
            default:     code_colour = COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/judgement_plotter_glyph_rom.sv
// 8x8 judgement glyph bitmaps; bit 7 of each row byte is column 0.
module glyph_rom
    import judgement_plotter_pkg::*;
(
    input  logic [1:0] code,
    input  logic [2:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [7:0] row_bits;

    always_comb begin
        row_bits = 8'h00;
        case (code)
            ACC_PERFECT: begin
                case (row)
                    3'd0: row_bits = 8'h7C;
                    3'd1: row_bits = 8'h42;
                    3'd2: row_bits = 8'h42;
                    3'd3: row_bits = 8'h7C;
                    3'd4: row_bits = 8'h40;
                    3'd5: row_bits = 8'h40;
                    3'd6: row_bits = 8'h40;
                    default: row_bits = 8'h00;
                endcase
            end
            ACC_GOOD: begin
                case (row)
                    3'd0: row_bits = 8'h3C;
                    3'd1: row_bits = 8'h42;
                    3'd2: row_bits = 8'h40;
                    3'd3: row_bits = 8'h4E;
                    3'd4: row_bits = 8'h42;
                    3'd5: row_bits = 8'h42;
                    3'd6: row_bits = 8'h3C;
                    default: row_bits = 8'h00;
                endcase
            end
            ACC_MISS: begin
                case (row)
                    3'd0: row_bits = 8'h42;
                    3'd1: row_bits = 8'h66;
                    3'd2: row_bits = 8'h5A;
                    3'd3: row_bits = 8'h42;
                    3'd4: row_bits = 8'h42;
                    3'd5: row_bits = 8'h42;
                    3'd6: row_bits = 8'h42;
                    default: row_bits = 8'h00;
                endcase
            end
            default: row_bits = 8'h00;
        endcase
    end

    assign pixel = row_bits[3'd7 - col];

endmodule

// File: rtl/judgement_plotter.sv
// Request-driven glyph scanner feeding vga_adapter: one pixel per clock,
// 64 pixels per judgement, with a one-deep last-wins pending slot.
module judgement_plotter
    import judgement_plotter_pkg::*;
#(
    parameter int unsigned ORIGIN_X = 76,
    parameter int unsigned ORIGIN_Y = 56
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] accuracy,
    input  logic       accuracy_valid,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [5:0] LAST_IDX = 6'(GLYPH_W * GLYPH_H - 1);

    logic [0:0] state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [1:0] active_q, active_d;
    logic [1:0] disp_q, disp_d;
    logic       pend_valid_q, pend_valid_d;
    logic [1:0] pend_code_q, pend_code_d;

    logic       pend_valid_nxt;
    logic [1:0] pend_code_nxt;
    logic       glyph_bit;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        active_d       = active_q;
        disp_d         = disp_q;
        pend_valid_d   = pend_valid_q;
        pend_code_d    = pend_code_q;
        // A strobe in the final pixel cycle still counts as pending.
        pend_valid_nxt = accuracy_valid | pend_valid_q;
        pend_code_nxt  = accuracy_valid ? accuracy : pend_code_q;

        case (state_q)
            ST_IDLE: begin
                if (accuracy_valid && (accuracy != disp_q)) begin
                    active_d = accuracy;
                    idx_d    = '0;
                    state_d  = ST_DRAW;
                end
            end
            default: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    disp_d       = active_q;
                    pend_valid_d = 1'b0;
                    if (pend_valid_nxt && (pend_code_nxt != active_q)) begin
                        active_d = pend_code_nxt;
                        state_d  = ST_DRAW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    pend_valid_d = pend_valid_nxt;
                    pend_code_d  = pend_code_nxt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            active_q     <= ACC_NONE;
            disp_q       <= ACC_NONE;
            pend_valid_q <= 1'b0;
            pend_code_q  <= ACC_NONE;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            disp_q       <= disp_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
        end
    end

    glyph_rom u_glyph_rom (
        .code  (active_q),
        .row   (idx_q[5:3]),
        .col   (idx_q[2:0]),
        .pixel (glyph_bit)
    );

    assign busy   = (state_q == ST_DRAW);
    assign plot   = busy;
    assign x      = 8'(ORIGIN_X) + {5'b0, idx_q[2:0]};
    assign y      = 7'(ORIGIN_Y) + {4'b0, idx_q[5:3]};
    assign colour = (busy && glyph_bit) ? code_colour(active_q) : COL_BLACK;

endmodule

// File: tb/tb_judgement_plotter.sv
// Scoreboard bench for judgement_plotter: a scan-level model queues expected
// pixels and busy state; a negedge monitor pops and compares.
module tb_judgement_plotter;

    localparam int OX = 76;
    localparam int OY = 56;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] accuracy = 2'b00;
    logic       accuracy_valid = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    int checks = 0;
    int failures = 0;

    judgement_plotter #(.ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
        .clk            (clk),
        .rst            (rst),
        .accuracy       (accuracy),
        .accuracy_valid (accuracy_valid),
        .x              (x),
        .y              (y),
        .colour         (colour),
        .plot           (plot),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] glyph [4][8];
    logic [2:0] code_col [4];

    initial begin
        glyph[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        glyph[1] = '{8'h7C, 8'h42, 8'h42, 8'h7C, 8'h40, 8'h40, 8'h40, 8'h00};
        glyph[2] = '{8'h3C, 8'h42, 8'h40, 8'h4E, 8'h42, 8'h42, 8'h3C, 8'h00};
        glyph[3] = '{8'h42, 8'h66, 8'h5A, 8'h42, 8'h42, 8'h42, 8'h42, 8'h00};
        code_col = '{3'b000, 3'b010, 3'b001, 3'b100};
    end

    // Reference model: cycles left in the current scan, what is on screen,
    // and the single pending request.
    logic [17:0] exp_q [$];
    int          rem = 0;
    logic [1:0]  m_active = 2'b00;
    logic [1:0]  m_disp = 2'b00;
    logic        m_pend = 1'b0;
    logic [1:0]  m_pend_code = 2'b00;
    logic        exp_busy_cur = 1'b0;
    logic        mon_en = 1'b0;
    int          plot_count = 0;

    task automatic start_scan(input logic [1:0] c);
        logic [7:0] rowbits;
        logic       b;
        m_active = c;
        rem = 64;
        for (int k = 0; k < 64; k++) begin
            rowbits = glyph[c][k / 8];
            b = rowbits[7 - (k % 8)];
            exp_q.push_back({8'(OX + k % 8), 7'(OY + k / 8), b ? code_col[c] : 3'b000});
        end
    endtask

    task automatic model_step(input logic v, input logic [1:0] c);
        if (rem == 0) begin
            if (v && c != m_disp) start_scan(c);
        end else begin
            if (v) begin
                m_pend = 1'b1;
                m_pend_code = c;
            end
            rem--;
            if (rem == 0) begin
                m_disp = m_active;
                if (m_pend && m_pend_code != m_disp) start_scan(m_pend_code);
                m_pend = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [1:0] c);
        @(posedge clk);
        #1;
        exp_busy_cur = (rem != 0);
        accuracy_valid = v;
        accuracy = c;
        model_step(v, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_plot", int'(plot), 0);
        check("async_rst_busy", int'(busy), 0);
        accuracy_valid = 1'b0;
        exp_q.delete();
        rem = 0;
        m_disp = 2'b00;
        m_pend = 1'b0;
        exp_busy_cur = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst && mon_en) begin
            check("busy", int'(busy), int'(exp_busy_cur));
            check("plot", int'(plot), int'(exp_busy_cur));
            if (plot) begin
                plot_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pixel_unexpected actual=(%0d,%0d,%0d) required=none", x, y, colour);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    if ({x, y, colour} != e) begin
                        failures++;
                        $display("FAIL pixel actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                                 x, y, colour, e[17:10], e[9:3], e[2:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2;
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_x", int'(x), OX);
        check("rst_y", int'(y), OY);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        mon_en = 1'b1;

        // Perfect, repeated perfect (ignored), then miss.
        idle(9);
        cycle(1'b1, 2'b01);
        idle(70);
        cycle(1'b1, 2'b01);
        idle(5);
        cycle(1'b1, 2'b11);
        idle(70);

        // Good with two overlapping requests; last one (perfect) wins.
        plot_count = 0;
        cycle(1'b1, 2'b10);
        idle(20);
        cycle(1'b1, 2'b11);
        idle(19);
        cycle(1'b1, 2'b01);
        idle(100);
        check("back_to_back_plots", plot_count, 128);

        // Clear, then a second clear is ignored.
        cycle(1'b1, 2'b00);
        idle(70);
        plot_count = 0;
        cycle(1'b1, 2'b00);
        idle(10);
        check("clear_ignored", plot_count, 0);

        // Reset in the middle of a scan, then a full good scan.
        cycle(1'b1, 2'b11);
        idle(30);
        do_reset();
        cycle(1'b1, 2'b10);
        idle(70);

        // Strobe in the index-63 cycle chains straight into the next scan.
        plot_count = 0;
        cycle(1'b1, 2'b01);
        idle(63);
        cycle(1'b1, 2'b11);
        idle(70);
        check("coincident_chain_plots", plot_count, 128);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cycle(1'b1, 2'($urandom_range(0, 3)));
            else cycle(1'b0, 2'b00);
        end

        for (int i = 0; i < 200 && rem != 0; i++) idle(1);
        idle(3);
        check("model_drained", rem, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
